// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, common command codes and the
// odd-parity helper used when a command byte is framed.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      INHIBIT   = 3'd1,
      REQ       = 3'd2,
      DATA      = 3'd3,
      ACK       = 3'd4,
      WAIT_IDLE = 3'd5
   } ps2_tx_state_t;

   localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
   localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
   localparam logic [7:0] PS2_RESP_ACK   = 8'hFA;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a raw PS/2 pin plus a registered falling-edge strobe.
// Flops reset to 1 because the bus idles high; this avoids a false edge after reset.
module ps2_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic fall
);

   logic [2:0] sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= 3'b111;
         fall <= 1'b0;
      end else begin
         sync <= {sync[1:0], din};
         fall <= sync[2] & ~sync[1];
      end
   end

   assign level = sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter; only ever pulls the bus lines low.
// Define PS2_TX_TIMEOUT_EN to build the inter-edge watchdog that drives error.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | lines released, tx_ready high, waiting for a command
// INHIBIT   | clock held low for INHIBIT_CYCLES to abort device traffic
// REQ       | one cycle: clock released, data low (start bit / request)
// DATA      | device clocks out 8 data bits, parity, then stop (release)
// ACK       | waiting for the device's acknowledge clock pulse
// WAIT_IDLE | waiting for both lines high before reporting done
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       done,
   output logic       ack_ok,
   output logic       error,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe
);

   localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);

   ps2_tx_state_t    state, state_nxt;
   logic [INH_W-1:0] inh_cnt, inh_cnt_nxt;
   logic [8:0]       shift, shift_nxt;
   logic [3:0]       bit_cnt, bit_cnt_nxt;
   logic             clk_oe_nxt, dat_oe_nxt, done_nxt, ack_nxt, ready_nxt;
   logic             clk_sync, clk_fall, dat_sync, dat_fall_unused;

   ps2_sync_edge u_clk_sync (
      .clk   (Clk),
      .rst_n (Reset_n),
      .din   (ps2_clk_in),
      .level (clk_sync),
      .fall  (clk_fall)
   );

   ps2_sync_edge u_dat_sync (
      .clk   (Clk),
      .rst_n (Reset_n),
      .din   (ps2_dat_in),
      .level (dat_sync),
      .fall  (dat_fall_unused)
   );

`ifdef PS2_TX_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_cnt, wd_cnt_nxt;
   logic            err_q, err_nxt;
   assign error = err_q;
`else
   assign error = 1'b0;
`endif

   always_comb begin
      state_nxt   = state;
      inh_cnt_nxt = inh_cnt;
      shift_nxt   = shift;
      bit_cnt_nxt = bit_cnt;
      clk_oe_nxt  = ps2_clk_oe;
      dat_oe_nxt  = ps2_dat_oe;
      done_nxt    = 1'b0;
      ack_nxt     = ack_ok;
`ifdef PS2_TX_TIMEOUT_EN
      wd_cnt_nxt  = wd_cnt;
      err_nxt     = err_q;
`endif
      case (state)
         IDLE: begin
            clk_oe_nxt = 1'b0;
            dat_oe_nxt = 1'b0;
            if (tx_valid && tx_ready) begin
               shift_nxt   = {odd_parity(tx_data), tx_data};
               ack_nxt     = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
               err_nxt     = 1'b0;
`endif
               inh_cnt_nxt = INH_W'(INHIBIT_CYCLES - 1);
               clk_oe_nxt  = 1'b1;
               state_nxt   = INHIBIT;
            end
         end
         INHIBIT: begin
            if (inh_cnt == '0) begin
               clk_oe_nxt = 1'b0;
               dat_oe_nxt = 1'b1;
               state_nxt  = REQ;
            end else begin
               inh_cnt_nxt = inh_cnt - 1'b1;
            end
         end
         REQ: begin
            bit_cnt_nxt = '0;
`ifdef PS2_TX_TIMEOUT_EN
            wd_cnt_nxt  = WD_W'(TIMEOUT_CYCLES - 1);
`endif
            state_nxt   = DATA;
         end
         DATA: begin
            if (clk_fall) begin
               bit_cnt_nxt = bit_cnt + 1'b1;
               // tenth fall: release data so the device sees the stop bit
               if (bit_cnt == 4'd9) begin
                  dat_oe_nxt = 1'b0;
                  state_nxt  = ACK;
               end else begin
                  dat_oe_nxt = ~shift[0];
                  shift_nxt  = {1'b0, shift[8:1]};
               end
            end
         end
         ACK: begin
            if (clk_fall) begin
               ack_nxt   = ~dat_sync;
               state_nxt = WAIT_IDLE;
            end
         end
         WAIT_IDLE: begin
            if (clk_sync && dat_sync) begin
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
`ifdef PS2_TX_TIMEOUT_EN
      // a fall always reloads, so a same-cycle fall beats expiry
      if (state inside {DATA, ACK, WAIT_IDLE}) begin
         if (clk_fall) begin
            wd_cnt_nxt = WD_W'(TIMEOUT_CYCLES - 1);
         end else if (wd_cnt == '0) begin
            err_nxt    = 1'b1;
            ack_nxt    = 1'b0;
            clk_oe_nxt = 1'b0;
            dat_oe_nxt = 1'b0;
            done_nxt   = 1'b1;
            state_nxt  = IDLE;
         end else begin
            wd_cnt_nxt = wd_cnt - 1'b1;
         end
      end
`endif
      ready_nxt = (state_nxt == IDLE) && !done_nxt;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= IDLE;
         inh_cnt    <= '0;
         shift      <= '0;
         bit_cnt    <= '0;
         ps2_clk_oe <= 1'b0;
         ps2_dat_oe <= 1'b0;
         done       <= 1'b0;
         ack_ok     <= 1'b0;
         tx_ready   <= 1'b1;
      end else begin
         state      <= state_nxt;
         inh_cnt    <= inh_cnt_nxt;
         shift      <= shift_nxt;
         bit_cnt    <= bit_cnt_nxt;
         ps2_clk_oe <= clk_oe_nxt;
         ps2_dat_oe <= dat_oe_nxt;
         done       <= done_nxt;
         ack_ok     <= ack_nxt;
         tx_ready   <= ready_nxt;
      end
   end

`ifdef PS2_TX_TIMEOUT_EN
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         wd_cnt <= '0;
         err_q  <= 1'b0;
      end else begin
         wd_cnt <= wd_cnt_nxt;
         err_q  <= err_nxt;
      end
   end
`endif

endmodule
